// File: rtl/cu_run_pkg.sv
// Shared types for the CU run sequencer: FSM states, stop reasons, byte-lane helper.
package cu_run_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LD_RD    = 3'd1,
        S_LD_WR    = 3'd2,
        S_RST_HOLD = 3'd3,
        S_RUN      = 3'd4,
        S_DONE     = 3'd5
    } run_state_t;

    typedef enum logic [1:0] {
        STOP_NONE   = 2'd0,
        STOP_HALT   = 2'd1,
        STOP_BUDGET = 2'd2
    } stop_reason_t;

    localparam int BYTE_W = 8;

    function automatic int byte_lanes(input int data_w);
        return data_w / BYTE_W;
    endfunction

endpackage

// File: rtl/cu_trace_ring.sv
// Ring of the most recent (pc, ir) pairs with saturating occupancy count.
// Writes take effect next cycle; indexed read is combinational, index 0 = newest.
module cu_trace_ring #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic [DATA_W-1:0]          pc,
    input  logic [DATA_W-1:0]          ir,
    input  logic [$clog2(DEPTH)-1:0]   idx,
    output logic [DATA_W-1:0]          rd_pc,
    output logic [DATA_W-1:0]          rd_ir,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int IW = $clog2(DEPTH);

    logic [DATA_W-1:0] pc_mem [DEPTH];
    logic [DATA_W-1:0] ir_mem [DEPTH];
    logic [IW-1:0]     wr_ptr;
    logic [IW-1:0]     rd_ptr;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i] <= '0;
                ir_mem[i] <= '0;
            end
        end else if (push) begin
            pc_mem[wr_ptr] <= pc;
            ir_mem[wr_ptr] <= ir;
            wr_ptr         <= wr_ptr + 1'b1;
            if (count != (IW+1)'(DEPTH))
                count <= count + 1'b1;
        end
    end

    // wr_ptr points one past the newest entry; pointer arithmetic wraps naturally
    always_comb begin
        rd_ptr = wr_ptr - 1'b1 - idx;
        rd_pc  = pc_mem[rd_ptr];
        rd_ir  = ir_mem[rd_ptr];
    end

endmodule

// File: rtl/cu_run_sequencer.sv
// Loads a word image big-endian into the CU byte RAM (5 cycles/word), holds CU reset
// RST_CYCLES, then runs under a cycle budget until halt PC; trace ring under CU_TRACE_EN.
module cu_run_sequencer
    import cu_run_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int IMG_AW      = 6,
    parameter int RAM_AW      = 8,
    parameter int CYC_W       = 16,
    parameter int RST_CYCLES  = 4,
    parameter int TRACE_DEPTH = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [IMG_AW:0]       img_len,
    input  logic [CYC_W-1:0]      cycle_budget,
    input  logic [DATA_W-1:0]     halt_pc,
    output logic [IMG_AW-1:0]     img_rd_addr,
    input  logic [DATA_W-1:0]     img_rd_data,
    output logic                  ram_we,
    output logic [RAM_AW-1:0]     ram_addr,
    output logic [7:0]            ram_wdata,
    output logic                  cu_reset_n,
    output logic                  cu_clk_en,
    input  logic [DATA_W-1:0]     pc_in,
    input  logic [DATA_W-1:0]     ir_in,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [CYC_W-1:0]      cycles
`ifdef CU_TRACE_EN
    ,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
    output logic [DATA_W-1:0]              trace_pc,
    output logic [DATA_W-1:0]              trace_ir,
    output logic [$clog2(TRACE_DEPTH):0]   trace_count
`endif
);
    localparam int LANES = byte_lanes(DATA_W);
    localparam int BW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int RW    = $clog2(RST_CYCLES + 1);

    run_state_t        state;
    stop_reason_t      stop;
    logic [IMG_AW:0]   len_q;
    logic [IMG_AW-1:0] word_idx;
    logic [BW-1:0]     byte_idx;
    logic [RW-1:0]     rst_cnt;
    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] cur_word;
    logic [7:0]        byte_sel;
    logic              start_ok;
    logic              last_byte;
    logic              last_word;

    // The image word arrives during the first LD_WR cycle, so byte 0 bypasses word_q
    always_comb begin
        cur_word  = (byte_idx == '0) ? img_rd_data : word_q;
        byte_sel  = cur_word[(LANES - 1 - int'(byte_idx)) * 8 +: 8];
        last_byte = (byte_idx == BW'(LANES - 1));
        last_word = (({1'b0, word_idx} + 1'b1) == len_q);
        start_ok  = start && ((state == S_IDLE) || (state == S_DONE));
        stop      = STOP_NONE;
        if (pc_in == halt_pc)
            stop = STOP_HALT;
        else if ((cycle_budget != '0) && ((cycles + CYC_W'(1)) == cycle_budget))
            stop = STOP_BUDGET;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= S_IDLE;
            len_q       <= '0;
            word_idx    <= '0;
            byte_idx    <= '0;
            rst_cnt     <= '0;
            word_q      <= '0;
            img_rd_addr <= '0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            cu_reset_n  <= 1'b0;
            cu_clk_en   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycles      <= '0;
        end else begin
            ram_we <= 1'b0;
            if (abort) begin
                state      <= S_IDLE;
                cu_reset_n <= 1'b0;
                cu_clk_en  <= 1'b0;
                busy       <= 1'b0;
                done       <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start_ok) begin
                            cycles      <= '0;
                            timeout     <= 1'b0;
                            done        <= 1'b0;
                            busy        <= 1'b1;
                            len_q       <= img_len;
                            word_idx    <= '0;
                            byte_idx    <= '0;
                            rst_cnt     <= '0;
                            img_rd_addr <= '0;
                            cu_reset_n  <= 1'b0;
                            if (img_len != '0) begin
                                state     <= S_LD_RD;
                                cu_clk_en <= 1'b0;
                            end else begin
                                state     <= S_RST_HOLD;
                                cu_clk_en <= 1'b1;
                            end
                        end
                    end
                    S_LD_RD: begin
                        byte_idx <= '0;
                        state    <= S_LD_WR;
                    end
                    S_LD_WR: begin
                        if (byte_idx == '0)
                            word_q <= img_rd_data;
                        ram_we    <= 1'b1;
                        ram_addr  <= RAM_AW'(word_idx) * RAM_AW'(LANES) + RAM_AW'(byte_idx);
                        ram_wdata <= byte_sel;
                        if (!last_byte) begin
                            byte_idx <= byte_idx + 1'b1;
                        end else if (last_word) begin
                            state     <= S_RST_HOLD;
                            rst_cnt   <= '0;
                            cu_clk_en <= 1'b1;
                        end else begin
                            word_idx    <= word_idx + 1'b1;
                            img_rd_addr <= word_idx + 1'b1;
                            state       <= S_LD_RD;
                        end
                    end
                    S_RST_HOLD: begin
                        if (rst_cnt == RW'(RST_CYCLES - 1)) begin
                            state      <= S_RUN;
                            cu_reset_n <= 1'b1;
                        end else begin
                            rst_cnt <= rst_cnt + 1'b1;
                        end
                    end
                    S_RUN: begin
                        cycles <= cycles + 1'b1;
                        if (stop != STOP_NONE) begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            cu_clk_en <= 1'b0;
                            timeout   <= (stop == STOP_BUDGET);
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef CU_TRACE_EN
    cu_trace_ring #(
        .DATA_W (DATA_W),
        .DEPTH  (TRACE_DEPTH)
    ) u_trace (
        .clk    (Clk),
        .reset  (Reset),
        .clear  (start_ok && !abort),
        .push   ((state == S_RUN) && !abort),
        .pc     (pc_in),
        .ir     (ir_in),
        .idx    (trace_idx),
        .rd_pc  (trace_pc),
        .rd_ir  (trace_ir),
        .count  (trace_count)
    );
`else
    logic unused_ir;
    assign unused_ir = ^ir_in;
`endif

endmodule
